// File: rtl/sparc_pkg.sv
// sparc_pkg: shared fetch-state enum and datapath constants
package sparc_pkg;
    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FAULT} fetch_state_t;
    localparam int INSTR_W = 32;
    localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/fetch_timeout_ctr.sv
// fetch_timeout_ctr: counts unacknowledged request cycles, flags the cycle the count reaches TIMEOUT
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset || clr) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
    end
    assign expired = inc && (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer and single-entry instruction register with stall, delayed-branch redirect and sticky fault
// Define FETCH_ANNUL_EN to let annul_i squash the delay slot on a redirect.
module fetch_ctrl
    import sparc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_err,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_target,
    input  logic               annul_i,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [31:0]        instr_pc,
    output logic               fault,
    output logic [31:0]        fault_pc
);
    fetch_state_t state;
    logic [31:0] pc;
    logic fire, bus_err, expired, waiting, squash;
`ifdef FETCH_ANNUL_EN
    assign squash = annul_i;
`else
    logic unused_annul;
    assign unused_annul = annul_i;
    assign squash = 1'b0;
`endif
    assign imem_addr = pc;
    assign imem_req  = (state == ST_RUN) && !redirect_i && (!instr_valid || !stall_i);
    assign fire      = imem_req && imem_ack && !imem_err;
    assign bus_err   = imem_req && imem_ack && imem_err;
    assign waiting   = imem_req && !imem_ack;
    fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .inc    (waiting),
        .clr    (!waiting),
        .expired(expired)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
            fault       <= 1'b0;
            fault_pc    <= '0;
        end else if (state == ST_BOOT) begin
            state <= ST_RUN;
        end else if (state == ST_RUN) begin
            // redirect leaves the instruction register alone so the delay slot still issues
            if (redirect_i) begin
                pc <= redirect_target;
                if (redirect_target[1:0] != 2'b00) begin
                    state       <= ST_FAULT;
                    fault       <= 1'b1;
                    fault_pc    <= redirect_target;
                    instr_valid <= 1'b0;
                end else if (squash) instr_valid <= 1'b0;
            end else if (bus_err || expired) begin
                state       <= ST_FAULT;
                fault       <= 1'b1;
                fault_pc    <= pc;
                instr_valid <= 1'b0;
            end else if (fire) begin
                instr_out   <= imem_rdata;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
                pc          <= pc + PC_INC;
            end else if (instr_valid && !stall_i) instr_valid <= 1'b0;
        end
    end
endmodule
